// File: rtl/xspi_retry_arbiter.sv
// Two-port round-robin scheduler in front of xspi_top.
// Re-issues a transaction on CRC error and returns one response per request.
module xspi_retry_arbiter #(
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_cmd,
  input  logic [47:0] req0_addr,
  input  logic [63:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_cmd,
  input  logic [47:0] req1_addr,
  input  logic [63:0] req1_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [1:0]  rsp_status,
  output logic [3:0]  rsp_retries,
  output logic [63:0] rsp_rdata,
  output logic        x_start,
  output logic [7:0]  x_command,
  output logic [47:0] x_address,
  output logic [63:0] x_wr_data,
  input  logic        x_ready,
  input  logic        x_done,
  input  logic [63:0] x_rd_data,
  input  logic        x_crc_ca_error_slave,
  input  logic        x_crc_data_error_slave,
  input  logic        x_crc_data_error_master
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RETRY = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'hFF;

  localparam logic [3:0]  RMAX = 4'(MAX_RETRY);
  localparam logic [16:0] TMAX = 17'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_CRC = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  logic [2:0]  state;
  logic        last_grant;
  logic [3:0]  retry_cnt;
  logic [15:0] tcnt;
  logic [16:0] tcnt_nxt;

  logic        idle_rdy;
  logic        gnt0;
  logic        gnt1;
  logic        hs;
  logic [7:0]  sel_cmd;
  logic [47:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        sel_ill;

  logic        is_wr;
  logic        is_rd;
  logic        crc_err;
  logic        can_retry;
  logic        done_ok;
  logic        done_rty;
  logic        done_fail;
  logic        tmo_hit;

  always_comb begin
    idle_rdy = (state == S_IDLE) && x_ready;
    gnt0     = idle_rdy && req0_valid
               && (!req1_valid || last_grant);
    gnt1     = idle_rdy && req1_valid
               && (!req0_valid || !last_grant);
    hs       = gnt0 || gnt1;
  end

  always_comb begin
    sel_cmd   = gnt1 ? req1_cmd   : req0_cmd;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    sel_ill   = (sel_cmd != CMD_WR)
                && (sel_cmd != CMD_RD);
  end

  // Error term only looks at the flags that apply to the latched direction.
  always_comb begin
    is_wr     = (x_command == CMD_WR);
    is_rd     = (x_command == CMD_RD);
    crc_err   = x_crc_ca_error_slave
                | (is_wr & x_crc_data_error_slave)
                | (is_rd & x_crc_data_error_master);
    can_retry = (retry_cnt < RMAX);
    tcnt_nxt  = {1'b0, tcnt} + 17'd1;
    done_ok   = x_done && !crc_err;
    done_rty  = x_done && crc_err && can_retry;
    done_fail = x_done && crc_err && !can_retry;
    tmo_hit   = !x_done && (tcnt_nxt == TMAX);
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign x_start     = (state == S_ISSUE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_retries = retry_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      retry_cnt  <= '0;
      tcnt       <= '0;
      rsp_id     <= 1'b0;
      rsp_status <= ST_OK;
      rsp_rdata  <= '0;
      x_command  <= '0;
      x_address  <= '0;
      x_wr_data  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (hs) begin
            x_command  <= sel_cmd;
            x_address  <= sel_addr;
            x_wr_data  <= sel_wdata;
            rsp_id     <= gnt1;
            last_grant <= gnt1;
            retry_cnt  <= '0;
            rsp_rdata  <= '0;
            rsp_status <= sel_ill ? ST_ILL : ST_OK;
            state      <= sel_ill ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          tcnt <= tcnt_nxt[15:0];
          unique case (1'b1)
            done_ok: begin
              rsp_status <= ST_OK;
              rsp_rdata  <= is_rd ? x_rd_data : '0;
              state      <= S_RESP;
            end
            done_rty: begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= S_RETRY;
            end
            done_fail: begin
              rsp_status <= ST_CRC;
              rsp_rdata  <= is_rd ? x_rd_data : '0;
              state      <= S_RESP;
            end
            tmo_hit: begin
              rsp_status <= ST_TMO;
              rsp_rdata  <= '0;
              state      <= S_RESP;
            end
            default: ;
          endcase
        end
        S_RETRY: begin
          if (x_ready) begin
            state <= S_ISSUE;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xspi_retry_arbiter.sv
// Scoreboard bench for xspi_retry_arbiter with a behavioural xSPI slave
// and a transaction-level reference model.
`timescale 1ns/1ps
module tb_xspi_retry_arbiter;

  localparam int MR = 3;
  localparam int TO = 20;
  localparam logic [7:0] WR = 8'hA5;
  localparam logic [7:0] RD = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_cmd = '0, req1_cmd = '0;
  logic [47:0] req0_addr = '0, req1_addr = '0;
  logic [63:0] req0_wdata = '0, req1_wdata = '0;
  logic        rsp_valid, rsp_id;
  logic [1:0]  rsp_status;
  logic [3:0]  rsp_retries;
  logic [63:0] rsp_rdata;
  logic        x_start;
  logic [7:0]  x_command;
  logic [47:0] x_address;
  logic [63:0] x_wr_data;
  logic        x_ready = 1'b1, x_done = 1'b0;
  logic [63:0] x_rd_data = '0;
  logic        ca_err = 1'b0, ds_err = 1'b0, dm_err = 1'b0;

  always #5 clk = ~clk;

  xspi_retry_arbiter #(.MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_cmd(req0_cmd), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_cmd(req1_cmd), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_status(rsp_status), .rsp_retries(rsp_retries),
    .rsp_rdata(rsp_rdata),
    .x_start(x_start), .x_command(x_command),
    .x_address(x_address), .x_wr_data(x_wr_data),
    .x_ready(x_ready), .x_done(x_done),
    .x_rd_data(x_rd_data),
    .x_crc_ca_error_slave(ca_err),
    .x_crc_data_error_slave(ds_err),
    .x_crc_data_error_master(dm_err)
  );

  typedef struct {
    logic        id;
    logic [1:0]  status;
    logic [3:0]  retries;
    logic [63:0] rdata;
    int          starts;
    logic [7:0]  cmd;
    logic [47:0] addr;
    logic [63:0] wdata;
  } exp_t;

  exp_t        expq[$];
  exp_t        e;
  logic [63:0] mmem[logic [47:0]];
  logic [63:0] smem[logic [47:0]];
  int          total = 0;
  int          bad = 0;
  int          starts_seen = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          mlast = 1'b1;
  int          fail_n = 0;
  int          fail_kind = 0;
  bit          hang_req = 1'b0;
  int          att = 0;
  bit          prev_rsp = 1'b0;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference model: the outcome of one request, from the rules alone.
  function automatic exp_t model(bit p, logic [7:0] c,
                                 logic [47:0] a, logic [63:0] d,
                                 int nf, int kind, bit hang);
    exp_t r;
    bit   wr = (c == WR);
    bit   rd = (c == RD);
    int   eff;
    r.id = p; r.cmd = c; r.addr = a; r.wdata = d;
    r.rdata = '0; r.retries = '0;
    mlast = p;
    if (!wr && !rd) begin
      r.status = 2'b11; r.starts = 0;
      return r;
    end
    if (hang) begin
      r.status = 2'b10; r.starts = 1;
      return r;
    end
    eff = (kind == 0 || (kind == 1 && wr) || (kind == 2 && rd))
          ? nf : 0;
    if (eff > MR) begin
      r.status = 2'b01; r.retries = 4'(MR); r.starts = MR + 1;
    end else begin
      r.status = 2'b00; r.retries = 4'(eff); r.starts = eff + 1;
      if (wr) mmem[a] = d;
    end
    if (rd) r.rdata = mmem.exists(a) ? mmem[a] : 64'h0;
    return r;
  endfunction

  // Monitor: pops the scoreboard on every response.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("rdy_gate", (req0_ready | req1_ready) & ~x_ready, 0);
      check("rdy_excl", req0_ready & req1_ready, 0);
      if (x_start) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL start_unexp: got start want none");
        end else begin
          check("start_cmd", x_command, expq[0].cmd);
          check("start_addr", x_address, expq[0].addr);
          check("start_wdata", x_wr_data, expq[0].wdata);
          starts_seen++;
          start_cyc = cyc;
        end
      end
      if (rsp_valid) begin
        check("rsp_pulse", prev_rsp, 0);
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexp: got rsp want none");
        end else begin
          e = expq.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_status", rsp_status, e.status);
          check("rsp_retries", rsp_retries, e.retries);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("start_count", starts_seen, e.starts);
          if (e.status == 2'b10)
            check("tmo_lat", cyc - start_cyc, TO + 1);
          starts_seen = 0;
        end
      end
    end
    prev_rsp = rsp_valid;
  end

  // Behavioural xSPI slave with error injection and spurious done pulses.
  initial begin
    logic [7:0]  s_cmd;
    logic [47:0] s_addr;
    logic [63:0] s_wdata;
    bit busy, hanging, applied;
    int cnt;
    s_cmd = '0; s_addr = '0; s_wdata = '0;
    busy = 0; hanging = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      x_done = 0; ca_err = 0; ds_err = 0; dm_err = 0;
      x_rd_data = {$urandom, $urandom};
      if (x_start) begin
        s_cmd = x_command; s_addr = x_address; s_wdata = x_wr_data;
        busy = 1; hanging = hang_req;
        cnt = $urandom_range(1, 4);
        x_ready = hanging;
      end else if (busy && !hanging) begin
        cnt--;
        if (cnt == 0) begin
          busy = 0; x_done = 1;
          if (att < fail_n) begin
            ca_err = (fail_kind == 0);
            ds_err = (fail_kind == 1);
            dm_err = (fail_kind == 2);
          end else if (s_cmd == WR) begin
            dm_err = 1'($urandom % 2);
          end else begin
            ds_err = 1'($urandom % 2);
          end
          att++;
          applied = ca_err | ((s_cmd == WR) & ds_err)
                    | ((s_cmd == RD) & dm_err);
          if (s_cmd == RD)
            x_rd_data = smem.exists(s_addr) ? smem[s_addr] : 64'h0;
          if (s_cmd == WR && !applied) smem[s_addr] = s_wdata;
          x_ready = 1;
        end
      end else begin
        x_ready = ($urandom % 4) != 0;
        if (!busy && ($urandom % 8) == 0) begin
          x_done = 1;
          ca_err = 1'($urandom % 2);
          dm_err = 1'($urandom % 2);
        end
      end
    end
  end

  task automatic send(bit p, logic [7:0] c, logic [47:0] a,
                      logic [63:0] d);
    int n = 0;
    bit got = 0;
    if (p) begin
      req1_cmd = c; req1_addr = a; req1_wdata = d; req1_valid = 1;
    end else begin
      req0_cmd = c; req0_addr = a; req0_wdata = d; req0_valid = 1;
    end
    while (!got && n < 2000) begin
      @(negedge clk);
      got = p ? req1_ready : req0_ready;
      n++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL grant_timeout: port %0d got no grant", p);
    end
    @(posedge clk); #1;
    if (p) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic issue(bit p, logic [7:0] c, logic [47:0] a,
                       logic [63:0] d, int nf, int kind, bit hang);
    fail_n = nf; fail_kind = kind; hang_req = hang; att = 0;
    expq.push_back(model(p, c, a, d, nf, kind, hang));
    send(p, c, a, d);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 600) begin
      @(posedge clk); n++;
    end
    if (expq.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               expq.size());
      expq.delete();
      starts_seen = 0;
    end
    @(posedge clk); #1;
  endtask

  // Both ports hold requests continuously; order follows the model's rule.
  task automatic arb(int per_port);
    bit first = !mlast;
    logic [7:0]  c[2][4];
    logic [47:0] a[2][4];
    logic [63:0] d[2][4];
    fail_n = 0; hang_req = 0; att = 0;
    for (int k = 0; k < per_port; k++) begin
      for (int p = 0; p < 2; p++) begin
        c[p][k] = (p == 0) ? WR : RD;
        a[p][k] = 48'h100 + 48'(k);
        d[p][k] = {$urandom, $urandom};
      end
    end
    for (int k = 0; k < per_port; k++) begin
      expq.push_back(model(first, c[first][k], a[first][k],
                           d[first][k], 0, 0, 0));
      expq.push_back(model(!first, c[!first][k], a[!first][k],
                           d[!first][k], 0, 0, 0));
    end
    fork
      begin
        for (int k = 0; k < per_port; k++)
          send(0, c[0][k], a[0][k], d[0][k]);
      end
      begin
        for (int k = 0; k < per_port; k++)
          send(1, c[1][k], a[1][k], d[1][k]);
      end
    join
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] ad;
    int n;
    ad = 48'h6655443322AB;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x_start", x_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_x_command", x_command, 0);
    check("rst_x_address", x_address, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_retries", rsp_retries, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    issue(0, WR, ad, 64'h1122334455667788, 0, 0, 0);
    drain();
    issue(1, RD, ad, 64'h0, 0, 0, 0);
    drain();
    issue(0, WR, ad, 64'hCAFEF00DDEADBEEF, 2, 0, 0);
    drain();
    issue(1, RD, ad, 64'h0, 99, 2, 0);
    drain();
    arb(2);
    issue(0, WR, 48'h2222, 64'h5, 0, 0, 1);
    drain();
    issue(1, 8'h3C, 48'h3333, 64'h6, 0, 0, 0);
    drain();

    issue(0, RD, ad, 64'h0, 0, 0, 1);
    n = 0;
    while (starts_seen == 0 && n < 200) begin
      @(posedge clk); n++;
    end
    check("rst_test_start", starts_seen, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    check("midrst_x_start", x_start, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    expq.delete();
    starts_seen = 0;
    mlast = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    arb(1);

    for (int i = 0; i < 40; i++) begin
      bit          p;
      int          sel;
      logic [7:0]  c;
      p = 1'($urandom % 2);
      sel = $urandom % 5;
      if (sel < 2) c = WR;
      else if (sel < 4) c = RD;
      else begin
        c = 8'($urandom);
        if (c == WR || c == RD) c = 8'h00;
      end
      issue(p, c, 48'h500 + 48'($urandom % 4),
            {$urandom, $urandom}, $urandom % 6, $urandom % 3,
            ($urandom % 10) == 0);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
